// File: rtl/alu_pkg.sv
// Shared definitions for the time-multiplexed ALU: funct codes, ALU operation
// codes, scheduler state encoding and the ALUOp/Funct decoder.
package alu_pkg;

    localparam logic [5:0] F_ADD = 6'd32;
    localparam logic [5:0] F_SUB = 6'd34;
    localparam logic [5:0] F_AND = 6'd36;
    localparam logic [5:0] F_OR  = 6'd37;
    localparam logic [5:0] F_SLT = 6'd42;
    localparam logic [5:0] F_SLL = 6'd0;
    localparam logic [5:0] F_SRL = 6'd2;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [2:0] op;
    } dec_t;

    // Illegal encodings fall back to ALU_ADD with legal=0 so the datapath never
    // sees an undefined opcode; the caller forces the result to zero.
    function automatic dec_t alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
        dec_t d;
        d.legal = 1'b1;
        d.op    = ALU_ADD;
        case (aluop)
            2'b00: d.op = ALU_ADD;
            2'b01: d.op = ALU_SUB;
            2'b10: begin
                case (funct)
                    F_ADD:   d.op = ALU_ADD;
                    F_SUB:   d.op = ALU_SUB;
                    F_AND:   d.op = ALU_AND;
                    F_OR:    d.op = ALU_OR;
                    F_SLT:   d.op = ALU_SLT;
                    F_SLL:   d.op = ALU_SLL;
                    F_SRL:   d.op = ALU_SRL;
                    default: d.legal = 1'b0;
                endcase
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester after ptr (modulo
// NCORE) wins. Shared with the memory-port scheduler.
module rr_arbiter #(
    parameter int NCORE = 4,
    parameter int IW    = (NCORE > 1) ? $clog2(NCORE) : 1
) (
    input  logic [NCORE-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [NCORE-1:0] gnt,
    output logic [IW-1:0]    idx
);

    logic [IW-1:0] cand_s;
    logic [IW-1:0] idx_s;

    // Scan from the farthest candidate to the nearest so the closest requester after ptr wins.
    always_comb begin
        idx_s  = '0;
        cand_s = '0;
        for (int k = NCORE; k >= 1; k--) begin
            cand_s = IW'((int'(ptr) + k) % NCORE);
            idx_s  = req[cand_s] ? cand_s : idx_s;
        end
    end

    assign idx = idx_s;
    assign gnt = (|req) ? ({{(NCORE-1){1'b0}}, 1'b1} << idx_s) : {NCORE{1'b0}};

endmodule

// File: rtl/shared_alu_sched.sv
// One ALU shared by NCORE cores: round-robin pick in IDLE, execute on latched
// operands in EXEC, one-cycle done pulse to the served core in RESP.
module shared_alu_sched
    import alu_pkg::*;
#(
    parameter int NCORE = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCORE-1:0]       req,
    input  logic [2*NCORE-1:0]     aluop,
    input  logic [6*NCORE-1:0]     funct,
    input  logic [5*NCORE-1:0]     shamt,
    input  logic [WIDTH*NCORE-1:0] opa,
    input  logic [WIDTH*NCORE-1:0] opb,
    output logic [NCORE-1:0]       gnt,
    output logic [NCORE-1:0]       done,
    output logic [WIDTH-1:0]       result,
    output logic                   zero,
    output logic                   err,
    output logic                   busy
);

    localparam int IW = (NCORE > 1) ? $clog2(NCORE) : 1;

    state_t             state_r, state_nxt;
    logic [IW-1:0]      ptr_r, idx_r, arb_idx_s;
    logic [NCORE-1:0]   arb_gnt_s, gnt_r, done_r;
    logic [1:0]         aluop_r;
    logic [5:0]         funct_r;
    logic [4:0]         shamt_r;
    logic [WIDTH-1:0]   opa_r, opb_r, result_r, alu_raw_s, alu_out_s;
    logic               zero_r, err_r, busy_r;
    dec_t               dec_s;

    logic [1:0]         aluop_arr_s [NCORE];
    logic [5:0]         funct_arr_s [NCORE];
    logic [4:0]         shamt_arr_s [NCORE];
    logic [WIDTH-1:0]   opa_arr_s   [NCORE];
    logic [WIDTH-1:0]   opb_arr_s   [NCORE];

    for (genvar i = 0; i < NCORE; i++) begin : g_unpack
        assign aluop_arr_s[i] = aluop[2*i +: 2];
        assign funct_arr_s[i] = funct[6*i +: 6];
        assign shamt_arr_s[i] = shamt[5*i +: 5];
        assign opa_arr_s[i]   = opa[WIDTH*i +: WIDTH];
        assign opb_arr_s[i]   = opb[WIDTH*i +: WIDTH];
    end

    rr_arbiter #(.NCORE(NCORE), .IW(IW)) u_arb (
        .req (req),
        .ptr (ptr_r),
        .gnt (arb_gnt_s),
        .idx (arb_idx_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic: only IDLE waits, EXEC and RESP last exactly one cycle.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE: state_nxt = (|req) ? ST_EXEC : ST_IDLE;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ALU on the latched operands; illegal ops are forced to zero so no X escapes.
    always_comb begin
        dec_s     = alu_decode(aluop_r, funct_r);
        alu_raw_s = '0;
        case (dec_s.op)
            ALU_ADD: alu_raw_s = opa_r + opb_r;
            ALU_SUB: alu_raw_s = opa_r - opb_r;
            ALU_AND: alu_raw_s = opa_r & opb_r;
            ALU_OR:  alu_raw_s = opa_r | opb_r;
            ALU_SLT: alu_raw_s = {{(WIDTH-1){1'b0}}, ($signed(opa_r) < $signed(opb_r))};
            ALU_SLL: alu_raw_s = opb_r << shamt_r;
            ALU_SRL: alu_raw_s = opb_r >> shamt_r;
            default: alu_raw_s = '0;
        endcase
        alu_out_s = dec_s.legal ? alu_raw_s : {WIDTH{1'b0}};
    end

    // Operand capture, registered outputs and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_r    <= IW'(NCORE - 1);
            idx_r    <= '0;
            aluop_r  <= 2'b00;
            funct_r  <= 6'd0;
            shamt_r  <= 5'd0;
            opa_r    <= '0;
            opb_r    <= '0;
            gnt_r    <= '0;
            done_r   <= '0;
            result_r <= '0;
            zero_r   <= 1'b0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= '0;
                    if (|req) begin
                        idx_r   <= arb_idx_s;
                        aluop_r <= aluop_arr_s[arb_idx_s];
                        funct_r <= funct_arr_s[arb_idx_s];
                        shamt_r <= shamt_arr_s[arb_idx_s];
                        opa_r   <= opa_arr_s[arb_idx_s];
                        opb_r   <= opb_arr_s[arb_idx_s];
                        gnt_r   <= arb_gnt_s;
                        busy_r  <= 1'b1;
                    end else begin
                        gnt_r  <= '0;
                        busy_r <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    result_r <= alu_out_s;
                    zero_r   <= (alu_out_s == {WIDTH{1'b0}});
                    err_r    <= ~dec_s.legal;
                    gnt_r    <= '0;
                    done_r   <= {{(NCORE-1){1'b0}}, 1'b1} << idx_r;
                    busy_r   <= 1'b1;
                end
                ST_RESP: begin
                    ptr_r  <= idx_r;
                    done_r <= '0;
                    busy_r <= 1'b0;
                end
                default: begin
                    gnt_r  <= '0;
                    done_r <= '0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign gnt    = gnt_r;
    assign done   = done_r;
    assign result = result_r;
    assign zero   = zero_r;
    assign err    = err_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_shared_alu_sched.sv
// Self-checking bench for shared_alu_sched: directed scenarios plus randomized
// operations checked against a round-robin/arithmetic reference model.
module tb_shared_alu_sched;

    localparam int NCORE = 4;
    localparam int WIDTH = 32;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NCORE-1:0]       req;
    logic [2*NCORE-1:0]     aluop;
    logic [6*NCORE-1:0]     funct;
    logic [5*NCORE-1:0]     shamt;
    logic [WIDTH*NCORE-1:0] opa, opb;
    logic [NCORE-1:0]       gnt, done;
    logic [WIDTH-1:0]       result;
    logic                   zero, err, busy;

    shared_alu_sched #(.NCORE(NCORE), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .req(req), .aluop(aluop), .funct(funct),
        .shamt(shamt), .opa(opa), .opb(opb), .gnt(gnt), .done(done),
        .result(result), .zero(zero), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mptr;

    logic [1:0]  c_aluop [NCORE];
    logic [5:0]  c_funct [NCORE];
    logic [4:0]  c_shamt [NCORE];
    logic [31:0] c_a     [NCORE];
    logic [31:0] c_b     [NCORE];

    logic [NCORE-1:0] obs_gnt, obs_done_e, obs_done, obs_gnt_r;
    logic             obs_busy_e, obs_busy_r, obs_zero, obs_err;
    logic [31:0]      obs_result;
    time              obs_done_t;

    function automatic int model_pick(input logic [NCORE-1:0] r, input int p);
        for (int k = 1; k <= NCORE; k++) begin
            if (r[(p + k) % NCORE]) return (p + k) % NCORE;
        end
        return -1;
    endfunction

    function automatic logic [NCORE-1:0] onehot(input int w);
        logic [NCORE-1:0] v;
        v = '0;
        if (w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    // Reference arithmetic straight from the operation table.
    task automatic exp_alu(input int i, output logic [31:0] res, output logic e);
        logic [31:0] a, b;
        a = c_a[i]; b = c_b[i]; e = 1'b0; res = 32'd0;
        if (c_aluop[i] == 2'd0) res = a + b;
        else if (c_aluop[i] == 2'd1) res = a - b;
        else if (c_aluop[i] == 2'd3) e = 1'b1;
        else begin
            case (int'(c_funct[i]))
                32: res = a + b;
                34: res = a - b;
                36: res = a & b;
                37: res = a | b;
                42: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                0:  res = b << c_shamt[i];
                2:  res = b >> c_shamt[i];
                default: e = 1'b1;
            endcase
        end
    endtask

    task automatic rand_ops(input int i);
        int sel;
        logic [5:0] fl [7];
        fl = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0, 6'd2};
        sel = int'($urandom_range(0, 9));
        c_aluop[i] = (sel == 0) ? 2'd3 : (sel == 1) ? 2'd0 : (sel == 2) ? 2'd1 : 2'd2;
        c_funct[i] = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fl[$urandom_range(0, 6)];
        c_shamt[i] = 5'($urandom);
        c_a[i]     = $urandom;
        c_b[i]     = ($urandom_range(0, 5) == 0) ? c_a[i] : $urandom;
    endtask

    task automatic drive_ops();
        for (int i = 0; i < NCORE; i++) begin
            aluop[2*i +: 2]  = c_aluop[i];
            funct[6*i +: 6]  = c_funct[i];
            shamt[5*i +: 5]  = c_shamt[i];
            opa[32*i +: 32]  = c_a[i];
            opb[32*i +: 32]  = c_b[i];
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after RESP.
    task automatic do_txn(input logic [NCORE-1:0] r);
        req = r;
        drive_ops();
        @(negedge clk);
        obs_gnt = gnt; obs_busy_e = busy; obs_done_e = done;
        @(negedge clk);
        obs_done = done; obs_result = result; obs_zero = zero; obs_err = err;
        obs_gnt_r = gnt; obs_busy_r = busy; obs_done_t = $time;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] er; logic ee;
        reset = 1'b0;
        for (int i = 0; i < NCORE; i++) rand_ops(i);
        req = 4'b1111;
        drive_ops();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0 || result !== 32'd0
                || zero !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL reset_state gnt=%b done=%b busy=%b result=%h zero=%b err=%b exp all 0",
                         gnt, done, busy, result, zero, err);
            end
        end
        reset = 1'b1;
        mptr = NCORE - 1;
        do_txn(4'b1111);
        exp_alu(0, er, ee);
        checks++;
        if (obs_gnt !== 4'b0001) begin
            errors++; $display("FAIL reset_first_gnt got %b exp 0001", obs_gnt);
        end
        checks++;
        if (obs_done !== 4'b0001 || obs_result !== er || obs_err !== ee) begin
            errors++;
            $display("FAIL reset_first_done done=%b result=%h err=%b exp 0001 %h %b",
                     obs_done, obs_result, obs_err, er, ee);
        end
        mptr = 0;
    endtask

    task automatic test_single_sub();
        c_aluop[2] = 2'd2; c_funct[2] = 6'd34; c_shamt[2] = 5'd0;
        c_a[2] = 32'd5; c_b[2] = 32'd7;
        do_txn(4'b0100);
        checks++;
        if (obs_gnt !== 4'b0100 || obs_busy_e !== 1'b1 || obs_done_e !== 4'b0000) begin
            errors++;
            $display("FAIL core2_exec gnt=%b busy=%b done=%b exp 0100 1 0000", obs_gnt, obs_busy_e, obs_done_e);
        end
        checks++;
        if (obs_done !== 4'b0100 || obs_gnt_r !== 4'b0000 || obs_busy_r !== 1'b1) begin
            errors++;
            $display("FAIL core2_resp done=%b gnt=%b busy=%b exp 0100 0000 1", obs_done, obs_gnt_r, obs_busy_r);
        end
        checks++;
        if (obs_result !== 32'hFFFF_FFFE || obs_zero !== 1'b0 || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL core2_sub result=%h zero=%b err=%b exp fffffffe 0 0", obs_result, obs_zero, obs_err);
        end
        mptr = 2;
    endtask

    task automatic test_round_robin();
        logic [31:0] er; logic ee; int w; time last_t;
        last_t = 0;
        mptr = NCORE - 1;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < NCORE; i++) begin
            rand_ops(i); c_aluop[i] = 2'd0;
        end
        for (int n = 0; n < NCORE + 1; n++) begin
            w = model_pick(4'b1111, mptr);
            do_txn(4'b1111);
            exp_alu(w, er, ee);
            checks++;
            if (obs_done !== onehot(w) || $countones(obs_done) != 1 || obs_result !== er) begin
                errors++;
                $display("FAIL rr_order n=%0d done=%b result=%h exp %b %h", n, obs_done, obs_result, onehot(w), er);
            end
            if (n > 0) begin
                checks++;
                if (obs_done_t - last_t != 30) begin
                    errors++; $display("FAIL rr_spacing got %0t exp 30", obs_done_t - last_t);
                end
            end
            last_t = obs_done_t;
            mptr = w;
        end
    endtask

    task automatic test_shift_slt();
        c_aluop[1] = 2'd2; c_funct[1] = 6'd0; c_shamt[1] = 5'd4;
        c_a[1] = 32'hDEAD_BEEF; c_b[1] = 32'h8000_0001;
        do_txn(4'b0010);
        checks++;
        if (obs_done !== 4'b0010 || obs_result !== 32'h0000_0010 || obs_zero !== 1'b0 || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL sll done=%b result=%h zero=%b err=%b exp 0010 00000010 0 0",
                     obs_done, obs_result, obs_zero, obs_err);
        end
        c_funct[1] = 6'd42; c_a[1] = 32'hFFFF_FFFF; c_b[1] = 32'd1;
        do_txn(4'b0010);
        checks++;
        if (obs_result !== 32'd1 || obs_err !== 1'b0) begin
            errors++; $display("FAIL slt result=%h err=%b exp 00000001 0", obs_result, obs_err);
        end
        c_funct[1] = 6'd0; c_shamt[1] = 5'd31; c_b[1] = 32'h0000_0002;
        do_txn(4'b0010);
        checks++;
        if (obs_result !== 32'd0 || obs_zero !== 1'b1 || obs_err !== 1'b0) begin
            errors++; $display("FAIL sll_zero result=%h zero=%b err=%b exp 0 1 0", obs_result, obs_zero, obs_err);
        end
        mptr = 1;
    endtask

    task automatic test_illegal();
        c_aluop[3] = 2'd3; c_funct[3] = 6'd32; c_a[3] = 32'd3; c_b[3] = 32'd4;
        do_txn(4'b1000);
        checks++;
        if (obs_done !== 4'b1000 || obs_result !== 32'd0 || obs_zero !== 1'b1 || obs_err !== 1'b1) begin
            errors++;
            $display("FAIL illegal done=%b result=%h zero=%b err=%b exp 1000 0 1 1",
                     obs_done, obs_result, obs_zero, obs_err);
        end
        c_aluop[3] = 2'd1; c_a[3] = 32'd9; c_b[3] = 32'd9;
        do_txn(4'b1000);
        checks++;
        if (obs_result !== 32'd0 || obs_zero !== 1'b1 || obs_err !== 1'b0) begin
            errors++; $display("FAIL sub_zero result=%h zero=%b err=%b exp 0 1 0", obs_result, obs_zero, obs_err);
        end
        mptr = 3;
    endtask

    task automatic test_drop_in_exec();
        logic [31:0] er; logic ee;
        rand_ops(2);
        exp_alu(2, er, ee);
        req = 4'b0100;
        drive_ops();
        @(negedge clk);
        req = 4'b0000;
        checks++;
        if (gnt !== 4'b0100) begin
            errors++; $display("FAIL drop_gnt got %b exp 0100", gnt);
        end
        @(negedge clk);
        checks++;
        if (done !== 4'b0100 || result !== er || err !== ee) begin
            errors++; $display("FAIL drop_done done=%b result=%h err=%b exp 0100 %h %b", done, result, err, er, ee);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gnt !== 4'b0000 || done !== 4'b0000 || result !== er) begin
            errors++;
            $display("FAIL idle_hold busy=%b gnt=%b done=%b result=%h exp 0 0000 0000 %h", busy, gnt, done, result, er);
        end
        mptr = 2;
    endtask

    task automatic test_random();
        logic [31:0] er; logic ee; logic [NCORE-1:0] r; int w;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NCORE; i++) rand_ops(i);
            r = 4'($urandom_range(1, 15));
            w = model_pick(r, mptr);
            exp_alu(w, er, ee);
            do_txn(r);
            checks++;
            if (obs_gnt !== onehot(w) || obs_done !== onehot(w) || obs_result !== er
                || obs_zero !== (er == 32'd0) || obs_err !== ee) begin
                errors++;
                $display("FAIL random n=%0d req=%b gnt=%b done=%b result=%h zero=%b err=%b exp core %0d %h %b",
                         n, r, obs_gnt, obs_done, obs_result, obs_zero, obs_err, w, er, ee);
            end
            mptr = w;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] er; logic ee;
        for (int i = 0; i < NCORE; i++) rand_ops(i);
        req = 4'b0010;
        drive_ops();
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010) begin
            errors++; $display("FAIL mid_gnt got %b exp 0010", gnt);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 4'b0000 || busy !== 1'b0 || gnt !== 4'b0000) begin
            errors++; $display("FAIL mid_abandon done=%b busy=%b gnt=%b exp 0000 0 0000", done, busy, gnt);
        end
        reset = 1'b1;
        mptr = NCORE - 1;
        exp_alu(0, er, ee);
        do_txn(4'b0011);
        checks++;
        if (obs_gnt !== 4'b0001 || obs_done !== 4'b0001 || obs_result !== er) begin
            errors++;
            $display("FAIL mid_ptr gnt=%b done=%b result=%h exp 0001 0001 %h", obs_gnt, obs_done, obs_result, er);
        end
        mptr = 0;
    endtask

    initial begin
        reset = 1'b0;
        req   = '0;
        aluop = '0; funct = '0; shamt = '0; opa = '0; opb = '0;
        test_reset();
        test_single_sub();
        test_round_robin();
        test_shift_slt();
        test_illegal();
        test_drop_in_exec();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
